// File: rtl/touch_sense_mc_if.sv
// Core bus (cs/we/address) shared by the peripheral cores; the master drives requests and the core returns read data.
interface touch_sense_mc_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/touch_sense_mc.sv
// Multi-channel touch sensor handler: synchronise and debounce NUM_CH raw inputs, latch
// per-channel events (legacy latch FSM or edge mode) and count presses.
module touch_sense_mc #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] touch_event,
    touch_sense_mc_if.slave   bus
);
    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       ADDR_STATUS = 8'h09;
    localparam logic [7:0]       ADDR_LEVEL  = 8'h0a;
    localparam logic [7:0]       ADDR_CTRL   = 8'h0b;
    localparam logic [7:0]       ADDR_COUNT  = 8'h10;

    typedef enum logic [1:0] {ST_IDLE, ST_EVENT, ST_WAIT} ch_state_t;

    logic [NUM_CH-1:0] sync1, sync2, level, level_d, flag;
    logic [CNT_W-1:0]  deb_cnt   [NUM_CH];
    logic [7:0]        press_cnt [NUM_CH];
    ch_state_t         state     [NUM_CH];

    logic [NUM_CH-1:0] en_mask;
    logic              mode;
    logic [1:0]        edge_sel;

    logic              wr, ctrl_wr, status_wr, mode_flip;
    logic [NUM_CH-1:0] w1c, cnt_clr, rise, fall, edge_set, legacy_set;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^{bus.write_data[31:11], bus.write_data[7:0]};

    assign wr        = bus.cs && bus.we;
    assign ctrl_wr   = wr && (bus.address == ADDR_CTRL);
    assign status_wr = wr && (bus.address == ADDR_STATUS);
    assign mode_flip = ctrl_wr && (bus.write_data[8] != mode);
    assign w1c       = status_wr ? bus.write_data[NUM_CH-1:0] : '0;
    assign rise      = level & ~level_d;
    assign fall      = ~level & level_d;
    assign edge_set  = en_mask & ((rise & {NUM_CH{edge_sel[0]}}) | (fall & {NUM_CH{edge_sel[1]}}));
    assign bus.ready = bus.cs;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        cnt_clr    = '0;
        legacy_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_clr[i]    = wr && (bus.address == ADDR_COUNT + 8'(i));
            legacy_set[i] = (state[i] == ST_IDLE) && en_mask[i] && level[i];
        end
    end

    always_comb begin
        bus.read_data = '0;
        if (bus.cs) begin
            if (bus.address == ADDR_STATUS) begin
                bus.read_data[NUM_CH-1:0] = flag;
            end else if (bus.address == ADDR_LEVEL) begin
                bus.read_data[NUM_CH-1:0] = level;
            end else if (bus.address == ADDR_CTRL) begin
                bus.read_data[NUM_CH-1:0] = en_mask;
                bus.read_data[8]          = mode;
                bus.read_data[10:9]       = edge_sel;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (bus.address == ADDR_COUNT + 8'(i)) begin
                        bus.read_data[7:0] = press_cnt[i];
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            level_d  <= '0;
            flag     <= '0;
            en_mask  <= '1;
            mode     <= 1'b0;
            edge_sel <= 2'b01;
            // NOTE: these small per-channel arrays are state with defined reset values, so they are reset like any flop.
            for (int i = 0; i < NUM_CH; i++) begin
                deb_cnt[i]   <= '0;
                press_cnt[i] <= '0;
                state[i]     <= ST_IDLE;
            end
        end else begin
            sync1   <= touch_event;
            sync2   <= sync1;
            level_d <= level;

            if (ctrl_wr) begin
                en_mask  <= bus.write_data[NUM_CH-1:0];
                mode     <= bus.write_data[8];
                edge_sel <= bus.write_data[10:9];
            end

            for (int i = 0; i < NUM_CH; i++) begin
                // Debounce: level follows sync2 only after DEBOUNCE_CYCLES consecutive differing cycles.
                if (sync2[i] != level[i]) begin
                    if (deb_cnt[i] == CNT_LAST) begin
                        level[i]   <= ~level[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end

                if (cnt_clr[i]) begin
                    press_cnt[i] <= '0;
                end else if (rise[i] && en_mask[i] && (press_cnt[i] != 8'hff)) begin
                    press_cnt[i] <= press_cnt[i] + 8'd1;
                end

                // A set in the same cycle as W1C wins; a mode change overrides both.
                if (mode_flip) begin
                    flag[i]  <= 1'b0;
                    state[i] <= ST_IDLE;
                end else if (mode) begin
                    flag[i]  <= (flag[i] & ~w1c[i]) | edge_set[i];
                    state[i] <= ST_IDLE;
                end else begin
                    flag[i] <= (flag[i] & ~w1c[i]) | legacy_set[i];
                    case (state[i])
                        ST_IDLE:  if (en_mask[i] && level[i]) state[i] <= ST_EVENT;
                        ST_EVENT: if (w1c[i])                 state[i] <= ST_WAIT;
                        ST_WAIT:  if (!level[i])              state[i] <= ST_IDLE;
                        default:                              state[i] <= ST_IDLE;
                    endcase
                    if (!en_mask[i]) state[i] <= ST_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_touch_sense_mc.sv
// Directed bench for touch_sense_mc (NUM_CH=4, DEBOUNCE_CYCLES=4) with hand-computed expectations.
`timescale 1ns/1ps
module tb_touch_sense_mc;
    localparam int NUM_CH = 4;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] touch;
    int                checks = 0;
    int                errors = 0;

    touch_sense_mc_if bus_if();

    touch_sense_mc #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .reset       (reset),
        .touch_event (touch),
        .bus         (bus_if)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 ns after the n-th rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_if.cs      = 1'b1;
        bus_if.we      = 1'b0;
        bus_if.address = addr;
        #1;
        d = bus_if.read_data;
        bus_if.cs = 1'b0;
        #1;
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus_if.cs         = 1'b1;
        bus_if.we         = 1'b1;
        bus_if.address    = addr;
        bus_if.write_data = data;
        step(1);
        bus_if.cs = 1'b0;
        bus_if.we = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        touch             = '0;
        bus_if.cs         = 1'b0;
        bus_if.we         = 1'b0;
        bus_if.address    = '0;
        bus_if.write_data = '0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state and bus basics
        check("ready_idle", 32'(bus_if.ready), 32'd0);
        check("rdata_idle", bus_if.read_data, 32'd0);
        rdchk("ctrl_rst",   8'h0b, 32'h0000_020F);
        rdchk("status_rst", 8'h09, 32'd0);
        rdchk("level_rst",  8'h0a, 32'd0);
        bus_if.cs = 1'b1; bus_if.address = 8'h0b; #1;
        check("ready_cs", 32'(bus_if.ready), 32'd1);
        bus_if.cs = 1'b0; #1;
        rdchk("unmapped",   8'h20, 32'd0);
        rdchk("count4_oob", 8'h14, 32'd0);
        wr(8'h0b, 32'h0000_02FF);
        rdchk("ctrl_mask_hi", 8'h0b, 32'h0000_020F);

        // Legacy mode: hold ch2, flag exactly 7 cycles after the edge
        touch = 4'b0100;
        step(6);
        rdchk("st_t6",  8'h09, 32'd0);
        rdchk("lvl_t6", 8'h0a, 32'h4);
        step(1);
        rdchk("st_t7",  8'h09, 32'h4);
        rdchk("cnt2_1", 8'h12, 32'd1);
        wr(8'h09, 32'h4);
        rdchk("st_w1c", 8'h09, 32'd0);
        step(10);
        rdchk("st_no_reset", 8'h09, 32'd0);
        touch = 4'b0000;
        step(10);
        rdchk("lvl_rel", 8'h0a, 32'd0);
        rdchk("st_rel",  8'h09, 32'd0);
        touch = 4'b0100;
        step(10);
        rdchk("st_repress", 8'h09, 32'h4);
        rdchk("cnt2_2",     8'h12, 32'd2);
        wr(8'h09, 32'h4);
        touch = 4'b0000;
        step(10);

        // Glitch: 3-cycle pulse on ch1 never reaches the level
        touch = 4'b0010;
        step(3);
        touch = 4'b0000;
        step(10);
        rdchk("glitch_lvl", 8'h0a, 32'd0);
        rdchk("glitch_st",  8'h09, 32'd0);
        rdchk("glitch_cnt", 8'h11, 32'd0);

        // Counter clear coinciding with a press on ch1
        touch = 4'b0010;
        step(6);
        wr(8'h11, 32'd0);
        rdchk("cnt1_clr_wins", 8'h11, 32'd0);
        rdchk("st_ch1",        8'h09, 32'h2);
        wr(8'h09, 32'h2);
        touch = 4'b0000;
        step(10);

        // Edge mode, both edges, ch0
        wr(8'h0b, 32'h0000_070F);
        rdchk("ctrl_edge", 8'h0b, 32'h0000_070F);
        touch = 4'b0001;
        step(10);
        rdchk("edge_press", 8'h09, 32'h1);
        touch = 4'b0000;
        step(6);
        rdchk("lvl_fell", 8'h0a, 32'd0);
        wr(8'h09, 32'h1);
        rdchk("edge_set_wins", 8'h09, 32'h1);
        wr(8'h09, 32'h1);
        rdchk("edge_w1c", 8'h09, 32'd0);
        rdchk("cnt0_1",   8'h10, 32'd1);

        // 300 presses on ch3 saturate at 255
        for (int k = 0; k < 300; k++) begin
            touch = 4'b1000;
            step(8);
            touch = 4'b0000;
            step(8);
        end
        rdchk("cnt3_sat",   8'h13, 32'd255);
        rdchk("st_pending", 8'h09, 32'h8);

        // Mode flip clears flags, keeps counters
        wr(8'h0b, 32'h0000_020F);
        rdchk("flip_status", 8'h09, 32'd0);
        rdchk("flip_cnt3",   8'h13, 32'd255);
        rdchk("flip_cnt2",   8'h12, 32'd2);
        rdchk("flip_cnt0",   8'h10, 32'd1);
        wr(8'h13, 32'd0);
        rdchk("cnt3_clr", 8'h13, 32'd0);

        // Disabled ch0: level tracked, no flag, no count
        wr(8'h0b, 32'h0000_020E);
        touch = 4'b0001;
        step(10);
        rdchk("dis_st",  8'h09, 32'd0);
        rdchk("dis_cnt", 8'h10, 32'd1);
        rdchk("dis_lvl", 8'h0a, 32'h1);
        wr(8'h0b, 32'h0000_020F);
        step(1);
        rdchk("reen_set", 8'h09, 32'h1);

        // Reset mid-event with ch0 still held high
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rdchk("rst2_st",   8'h09, 32'd0);
        rdchk("rst2_lvl",  8'h0a, 32'd0);
        rdchk("rst2_ctrl", 8'h0b, 32'h0000_020F);
        rdchk("rst2_cnt2", 8'h12, 32'd0);
        step(3);
        rdchk("rst2_no_early", 8'h09, 32'd0);
        step(10);
        rdchk("rst2_late_evt", 8'h09, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
